iobus_ctrl: RTL
===============

# iobus_ctrl

Parametrised I/O bus controller between the address-space splitter and up to `SLOTS` peripherals. It decodes an I/O address into a slot index plus a peripheral-local address and runs a registered read/write access to the selected slot. It waits for that slot's ready, then returns data, a one-cycle `ready` pulse and an `error` flag for unmapped, illegal or timed-out accesses. It replaces the fixed single-slot bus and uses separate write and read data paths instead of a tristate bus.

## Interface
- `ADDR_WIDTH`, default `` `IO_ADDR_WIDTH `` (16): master address width.
- `DATA_WIDTH`, default `` `IO_DATA_WIDTH `` (32): data width on both the master and slot sides.
- `SLOT_ADDR_WIDTH`, default `` `PERIPH_ADDR_WIDTH `` (8): peripheral-local address width.
- `SLOTS`, default 4: number of peripheral slots, range 1..16.
- `TIMEOUT`, default 255: maximum number of ACCESS cycles; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `read`  in  1  master read request, level-held.
- `write`  in  1  master write request, level-held.
- `addr`  in  ADDR_WIDTH  master address.
- `wdata`  in  DATA_WIDTH  master write data.
- `rdata`  out  DATA_WIDTH  read data, registered.
- `ready`  out  1  one-cycle completion pulse.
- `error`  out  1  status of the access, valid while `ready`=1.
- `s_read`  out  SLOTS  per-slot read strobe (one-hot or zero).
- `s_write`  out  SLOTS  per-slot write strobe (one-hot or zero).
- `s_addr`  out  SLOT_ADDR_WIDTH  shared peripheral-local address.
- `s_wdata`  out  DATA_WIDTH  shared write data.
- `s_rdata`  in  SLOTS*DATA_WIDTH  flattened read data; slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `s_ready`  in  SLOTS  per-slot ready.

## Operation
- Decode:
  - SEL = clog2(SLOTS), minimum 1.
  - Slot index = `addr[SLOT_ADDR_WIDTH +: SEL]`.
  - Local address = `addr[SLOT_ADDR_WIDTH-1:0]`.
  - Mapped only if the index < SLOTS and all `addr` bits above SLOT_ADDR_WIDTH+SEL are zero.
- States are IDLE, ACCESS, DONE and RELEASE.
- IDLE: if `read|write`, latch the slot index, local address, `wdata` and direction.
  - Go to DONE with error=1 if the address is unmapped or `read&write`=1.
  - Otherwise go to ACCESS with the timeout counter cleared.
- ACCESS:
  - Drive the selected bit of `s_read` or `s_write`; `s_addr`/`s_wdata` are held stable.
  - Count cycles.
  - If `s_ready[sel]`=1: go to DONE with error=0. On a read, register the selected slot's `s_rdata` into `rdata`.
  - Else if TIMEOUT≠0 and count = TIMEOUT-1: go to DONE with error=1 and `rdata` set to 0.
  - `s_ready` of unselected slots is ignored.
- DONE: `ready`=1 for exactly one cycle, strobes are 0, then go to RELEASE.
- RELEASE: wait until `read`=0 and `write`=0, then go to IDLE. A held request never starts a second access.
- `rdata` holds its value until the next completed read or errored access. Writes do not change `rdata`.
- `error` is registered with `ready` and holds its value until the next DONE.
- Changes to `addr`/`wdata` after IDLE sampling are ignored for the current access.

## Timing
- Reset (async, `rst_n`=0): state IDLE.
  - `ready`, `error`, `rdata`, `s_read`, `s_write`, `s_addr` and `s_wdata` are all 0.
  - Strobes drop immediately even mid-ACCESS; no `ready` is issued for the aborted access.
- Request seen in IDLE at cycle 0:
  - Strobe asserted in cycle 1.
  - With `s_ready` high in cycle 1, `ready` is asserted in cycle 2.
  - Each extra wait cycle adds one.
- Decode error: `ready`/`error` asserted in cycle 1 and no slot strobe is ever asserted.
- Timeout: the strobe is asserted for exactly TIMEOUT cycles, and `ready`+`error` follow in the next cycle.
- `s_ready` arriving in the same cycle as the timeout count reaching TIMEOUT-1 wins, giving error=0.
- Minimum request-to-request spacing is 4 cycles: IDLE, ACCESS, DONE and at least one RELEASE cycle with strobes low.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Add to `constants.v`:
  - `` `IOBUS_SLOTS ``.
  - `` `IOBUS_TIMEOUT ``.
  - The 2-bit state encodings `` `IOBUS_IDLE/ACCESS/DONE/RELEASE ``.
- Reuse the existing `` `IO_*_WIDTH `` and `` `PERIPH_*_WIDTH `` constants.
- Sub-module `iobus_decoder`: combinational, `addr` → `slot_idx`, `local_addr`, `mapped`. It is separately testable.
- The FSM, timeout counter and read-data mux live in `iobus_ctrl`.

## Test plan
- Write with zero-wait slot: `write`=1, `addr`=0x0105, `wdata`=0xCAFEF00D.
  - Required: `s_write`=0b0010, `s_addr`=0x05, `s_wdata`=0xCAFEF00D in cycle 1.
  - Required: `ready`=1, `error`=0 in cycle 2.
  - Required: `rdata` unchanged.
- Read with wait states: `read`, `addr`=0x0310, slot 3 raises `s_ready` after 5 cycles with data 0x12345678.
  - Required: `s_read`=0b1000 for 5 cycles.
  - Required: `ready` in the next cycle with `rdata`=0x12345678 and `error`=0.
- Unmapped address: `addr`=0x0400 with SLOTS=4.
  - Required: `ready`=1 and `error`=1 in cycle 1.
  - Required: `s_read`/`s_write` stay 0.
- Illegal request: `read`=`write`=1. Required: same as the unmapped case.
- Timeout: TIMEOUT=8, slot never ready.
  - Required: strobe high for exactly 8 cycles.
  - Required: then `ready`=1, `error`=1, `rdata`=0.
- Release and reset:
  - Hold `read` high for 10 cycles after `ready`. Required: only one slot access occurs.
  - Assert `rst_n`=0 mid-ACCESS. Required: strobes drop asynchronously, no `ready`, and all outputs are 0.

Source files
------------

// File: rtl/iobus_ctrl_pkg.sv
// iobus_ctrl_pkg: shared constants, state encoding and sizing helpers for the
// I/O bus controller.
//   IO_*_WIDTH / PERIPH_ADDR_WIDTH : bus widths shared with the rest of the system
//   IOBUS_SLOTS / IOBUS_TIMEOUT    : controller defaults
//   IOBUS_IDLE..IOBUS_RELEASE      : 2-bit FSM state encodings
package iobus_ctrl_pkg;

    localparam int unsigned IO_ADDR_WIDTH     = 16;
    localparam int unsigned IO_DATA_WIDTH     = 32;
    localparam int unsigned PERIPH_ADDR_WIDTH = 8;

    localparam int unsigned IOBUS_SLOTS   = 4;
    localparam int unsigned IOBUS_TIMEOUT = 255;

    localparam logic [1:0] IOBUS_IDLE    = 2'd0;
    localparam logic [1:0] IOBUS_ACCESS  = 2'd1;
    localparam logic [1:0] IOBUS_DONE    = 2'd2;
    localparam logic [1:0] IOBUS_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = IOBUS_IDLE,
        StAccess  = IOBUS_ACCESS,
        StDone    = IOBUS_DONE,
        StRelease = IOBUS_RELEASE
    } iobus_state_e;

    // Slot-select width: clog2(slots), never below 1.
    function automatic int unsigned sel_width(input int unsigned slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    // Timeout counter only needs to reach TIMEOUT-1.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/iobus_decoder.sv
// iobus_decoder: combinational I/O address decode.
//   addr       in  : master address
//   slot_idx   out : slot index, addr[SLOT_ADDR_WIDTH +: SEL]
//   local_addr out : peripheral-local address, addr[SLOT_ADDR_WIDTH-1:0]
//   mapped     out : index < SLOTS and every address bit above the index is zero
module iobus_decoder
    import iobus_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = IO_ADDR_WIDTH,
    parameter int unsigned SLOT_ADDR_WIDTH = PERIPH_ADDR_WIDTH,
    parameter int unsigned SLOTS           = IOBUS_SLOTS,
    localparam int unsigned SEL            = sel_width(SLOTS)
) (
    input  logic [ADDR_WIDTH-1:0]      addr,
    output logic [SEL-1:0]             slot_idx,
    output logic [SLOT_ADDR_WIDTH-1:0] local_addr,
    output logic                       mapped
);

    localparam int unsigned Hi = SLOT_ADDR_WIDTH + SEL;

    logic upper_zero;

    generate
        if (ADDR_WIDTH > Hi) begin : g_upper
            assign upper_zero = ~|addr[ADDR_WIDTH-1:Hi];
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        slot_idx   = addr[SLOT_ADDR_WIDTH +: SEL];
        local_addr = addr[SLOT_ADDR_WIDTH-1:0];
        // Extra zero bit so SLOTS itself (e.g. 16 with SEL=4) is representable.
        mapped     = upper_zero && ({1'b0, slot_idx} < SLOTS[SEL:0]);
    end

endmodule

// File: rtl/iobus_ctrl.sv
// iobus_ctrl: registered I/O bus controller fanning one master out to SLOTS
// peripherals with separate read/write data paths.
//   clk, rst_n          : clock, asynchronous active-low reset
//   read, write         : level-held master request
//   addr, wdata         : master address / write data, sampled in IDLE
//   rdata, ready, error : registered response; ready is a one-cycle pulse
//   s_read, s_write     : one-hot (or zero) per-slot strobes
//   s_addr, s_wdata     : shared slot address / write data, stable for an access
//   s_rdata, s_ready    : flattened per-slot read data and per-slot ready
module iobus_ctrl
    import iobus_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = IO_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = IO_DATA_WIDTH,
    parameter int unsigned SLOT_ADDR_WIDTH = PERIPH_ADDR_WIDTH,
    parameter int unsigned SLOTS           = IOBUS_SLOTS,
    parameter int unsigned TIMEOUT         = IOBUS_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        read,
    input  logic                        write,
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        ready,
    output logic                        error,
    output logic [SLOTS-1:0]            s_read,
    output logic [SLOTS-1:0]            s_write,
    output logic [SLOT_ADDR_WIDTH-1:0]  s_addr,
    output logic [DATA_WIDTH-1:0]       s_wdata,
    input  logic [SLOTS*DATA_WIDTH-1:0] s_rdata,
    input  logic [SLOTS-1:0]            s_ready
);

    localparam int unsigned SEL = sel_width(SLOTS);
    localparam int unsigned CW  = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CntLast = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    iobus_state_e               state_q, state_d;
    logic [SEL-1:0]             sel_q, sel_d;
    logic                       is_read_q, is_read_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       ready_q, ready_d;
    logic                       error_q, error_d;
    logic [SLOTS-1:0]           s_read_q, s_read_d;
    logic [SLOTS-1:0]           s_write_q, s_write_d;
    logic [SLOT_ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0]      s_wdata_q, s_wdata_d;

    logic [SEL-1:0]             dec_idx;
    logic [SLOT_ADDR_WIDTH-1:0] dec_local;
    logic                       dec_mapped;
    logic [SLOTS-1:0]           dec_hot;
    logic                       sel_ready;
    logic [DATA_WIDTH-1:0]      sel_rdata;

    iobus_decoder #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .SLOT_ADDR_WIDTH (SLOT_ADDR_WIDTH),
        .SLOTS           (SLOTS)
    ) u_decoder (
        .addr       (addr),
        .slot_idx   (dec_idx),
        .local_addr (dec_local),
        .mapped     (dec_mapped)
    );

    // Loop-based muxes keep out-of-range indices (non power-of-two SLOTS) harmless.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        dec_hot   = '0;
        for (int k = 0; k < SLOTS; k++) begin
            dec_hot[k] = (dec_idx == SEL'(k));
            if (sel_q == SEL'(k)) begin
                sel_ready = s_ready[k];
                sel_rdata = s_rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        is_read_d = is_read_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        error_d   = error_q;
        s_read_d  = s_read_q;
        s_write_d = s_write_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;

        case (state_q)
            StIdle: begin
                if (read || write) begin
                    sel_d     = dec_idx;
                    s_addr_d  = dec_local;
                    s_wdata_d = wdata;
                    is_read_d = read;
                    if (!dec_mapped || (read && write)) begin
                        state_d = StDone;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = StAccess;
                        cnt_d   = '0;
                        if (read) s_read_d  = dec_hot;
                        else      s_write_d = dec_hot;
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 1'b1;
                // Ready is tested first so it wins over a same-cycle timeout.
                if (sel_ready) begin
                    state_d   = StDone;
                    ready_d   = 1'b1;
                    error_d   = 1'b0;
                    s_read_d  = '0;
                    s_write_d = '0;
                    if (is_read_q) rdata_d = sel_rdata;
                end else if (TIMEOUT != 0 && cnt_q == CntLast) begin
                    state_d   = StDone;
                    ready_d   = 1'b1;
                    error_d   = 1'b1;
                    rdata_d   = '0;
                    s_read_d  = '0;
                    s_write_d = '0;
                end
            end
            StDone: begin
                state_d = StRelease;
            end
            StRelease: begin
                if (!read && !write) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            is_read_q <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            s_read_q  <= '0;
            s_write_q <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            is_read_q <= is_read_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            s_read_q  <= s_read_d;
            s_write_q <= s_write_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign error   = error_q;
    assign s_read  = s_read_q;
    assign s_write = s_write_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;

endmodule
